cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the 4-bit CPU datapath: PC, instruction ROM, registers A/B, ALU and data selector. It sequences FETCH/EXECUTE, latches the instruction, and drives all register load enables, the PC increment/jump, the ALU operand select and the OUT port load. It keeps the carry flag used by JNC and adds run/single-step control for bring-up on the board.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_inst_decode.sv | 46 ++++
 rtl/cpu_sequencer.sv | 102 ++++++++++
 tb/tb_cpu_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, ALU operand select codes, opcodes and FSM state encoding
// for the 4-bit CPU sequencer.
package cpu_pkg;

  localparam int W  = 4;
  localparam int DW = 8;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

endpackage

// File: rtl/cpu_inst_decode.sv
// Combinational opcode decoder: maps opcode and the current carry flag to
// ALU select, register/OUT loads and PC control. Ungated; the FSM qualifies it.
module cpu_inst_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  output logic [1:0] alu_data_sel,
  output logic       reg_a_load,
  output logic       reg_b_load,
  output logic       out_load,
  output logic       out_src,
  output logic       imm_zero,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       is_add
);

  always_comb begin
    alu_data_sel = SEL_A;
    reg_a_load   = 1'b0;
    reg_b_load   = 1'b0;
    out_load     = 1'b0;
    out_src      = 1'b0;
    imm_zero     = 1'b0;
    pc_inc       = 1'b1;
    pc_jump      = 1'b0;
    is_add       = 1'b0;
    case (opcode)
      OP_ADD_A:  begin alu_data_sel = SEL_A;    reg_a_load = 1'b1; is_add = 1'b1; end
      OP_ADD_B:  begin alu_data_sel = SEL_B;    reg_b_load = 1'b1; is_add = 1'b1; end
      OP_MOV_A:  begin alu_data_sel = SEL_ZERO; reg_a_load = 1'b1; end
      OP_MOV_B:  begin alu_data_sel = SEL_ZERO; reg_b_load = 1'b1; end
      OP_MOV_AB: begin alu_data_sel = SEL_B;    reg_a_load = 1'b1; imm_zero = 1'b1; end
      OP_MOV_BA: begin alu_data_sel = SEL_A;    reg_b_load = 1'b1; imm_zero = 1'b1; end
      OP_IN_A:   begin alu_data_sel = SEL_IN;   reg_a_load = 1'b1; end
      OP_IN_B:   begin alu_data_sel = SEL_IN;   reg_b_load = 1'b1; end
      OP_OUT_B:  begin out_load = 1'b1; out_src = 1'b0; end
      OP_OUT_IM: begin out_load = 1'b1; out_src = 1'b1; end
      OP_JMP:    begin pc_inc = 1'b0; pc_jump = 1'b1; end
      OP_JNC:    begin pc_inc = carry_flag; pc_jump = ~carry_flag; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC control FSM for the 4-bit CPU: instruction latch, ROM wait
// counter, carry flag and run/single-step control.
//   state | meaning
//   IDLE  | halted, waiting for run or a step pulse
//   FETCH | waiting ROM_LAT cycles, latching rom_data on the last one
//   EXEC  | one-cycle strobes for the latched instruction
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int W            = cpu_pkg::W,
  parameter int DW           = cpu_pkg::DW,
  parameter int ROM_LAT      = 1,
  parameter int RUN_AT_RESET = 0
) (
  input  logic          clk_cpu,
  input  logic          reset_n,
  input  logic          run,
  input  logic          step,
  input  logic [DW-1:0] rom_data,
  input  logic          alu_carry_in,
  output logic [DW-1:0] inst,
  output logic [1:0]    alu_data_sel,
  output logic          reg_a_load,
  output logic          reg_b_load,
  output logic          out_load,
  output logic          out_src,
  output logic          imm_zero,
  output logic          pc_inc,
  output logic          pc_jump,
  output logic          carry_flag,
  output logic          halted,
  output logic [1:0]    state
);

  localparam state_t     RST_STATE = (RUN_AT_RESET != 0) ? ST_FETCH : ST_IDLE;
  localparam logic [1:0] WAIT_LAST = 2'(ROM_LAT - 1);

  state_t     st;
  logic [1:0] wait_cnt;
  logic       exec;

  logic [1:0] d_sel;
  logic       d_a_load, d_b_load, d_out_load, d_out_src, d_imm_zero;
  logic       d_pc_inc, d_pc_jump, d_is_add;

  cpu_inst_decode u_decode (
    .opcode       (inst[DW-1:W]),
    .carry_flag   (carry_flag),
    .alu_data_sel (d_sel),
    .reg_a_load   (d_a_load),
    .reg_b_load   (d_b_load),
    .out_load     (d_out_load),
    .out_src      (d_out_src),
    .imm_zero     (d_imm_zero),
    .pc_inc       (d_pc_inc),
    .pc_jump      (d_pc_jump),
    .is_add       (d_is_add)
  );

  // Strobes derive from state alone, so an async reset kills them at once.
  assign exec         = (st == ST_EXEC);
  assign alu_data_sel = exec ? d_sel : SEL_A;
  assign reg_a_load   = exec & d_a_load;
  assign reg_b_load   = exec & d_b_load;
  assign out_load     = exec & d_out_load;
  assign out_src      = exec & d_out_src;
  assign imm_zero     = exec & d_imm_zero;
  assign pc_inc       = exec & d_pc_inc;
  assign pc_jump      = exec & d_pc_jump;
  assign halted       = (st == ST_IDLE);
  assign state        = st;

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      st         <= RST_STATE;
      wait_cnt   <= '0;
      inst       <= '0;
      carry_flag <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (run || step) st <= ST_FETCH;
        end
        ST_FETCH: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            inst     <= rom_data;
            st       <= ST_EXEC;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_EXEC: begin
          carry_flag <= d_is_add & alu_carry_in;
          st         <= run ? ST_FETCH : ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two instances (ROM_LAT 1 and 3) share stimulus and
// are checked every cycle against an instruction-level model, plus literal checks.
module tb_cpu_sequencer;

  localparam int LAT [2] = '{1, 3};

  logic       clk_cpu = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0, step = 1'b0, alu_carry_in = 1'b0;
  logic [7:0] rom_data = 8'h00;

  logic [7:0] inst_o [2];
  logic [1:0] sel_o  [2];
  logic [1:0] st_o   [2];
  logic a_o [2], b_o [2], ol_o [2], os_o [2], iz_o [2];
  logic inc_o [2], jmp_o [2], cf_o [2], halt_o [2];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk_cpu = ~clk_cpu;

  cpu_sequencer #(.W(4), .DW(8), .ROM_LAT(1), .RUN_AT_RESET(0)) dut0 (
    .clk_cpu(clk_cpu), .reset_n(reset_n), .run(run), .step(step),
    .rom_data(rom_data), .alu_carry_in(alu_carry_in), .inst(inst_o[0]),
    .alu_data_sel(sel_o[0]), .reg_a_load(a_o[0]), .reg_b_load(b_o[0]),
    .out_load(ol_o[0]), .out_src(os_o[0]), .imm_zero(iz_o[0]),
    .pc_inc(inc_o[0]), .pc_jump(jmp_o[0]), .carry_flag(cf_o[0]),
    .halted(halt_o[0]), .state(st_o[0]));

  cpu_sequencer #(.W(4), .DW(8), .ROM_LAT(3), .RUN_AT_RESET(0)) dut1 (
    .clk_cpu(clk_cpu), .reset_n(reset_n), .run(run), .step(step),
    .rom_data(rom_data), .alu_carry_in(alu_carry_in), .inst(inst_o[1]),
    .alu_data_sel(sel_o[1]), .reg_a_load(a_o[1]), .reg_b_load(b_o[1]),
    .out_load(ol_o[1]), .out_src(os_o[1]), .imm_zero(iz_o[1]),
    .pc_inc(inc_o[1]), .pc_jump(jmp_o[1]), .carry_flag(cf_o[1]),
    .halted(halt_o[1]), .state(st_o[1]));

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Instruction table as {sel[1:0], a_load, b_load, out_load, out_src, imm_zero, pc_inc, pc_jump}.
  function automatic logic [8:0] spec_ctrl(input logic [3:0] op, input bit carry);
    case (op)
      4'h0: return 9'b00_10000_10;
      4'h5: return 9'b01_01000_10;
      4'h3: return 9'b11_10000_10;
      4'h7: return 9'b11_01000_10;
      4'h1: return 9'b01_10001_10;
      4'h4: return 9'b00_01001_10;
      4'h2: return 9'b10_10000_10;
      4'h6: return 9'b10_01000_10;
      4'h9: return 9'b00_00100_10;
      4'hB: return 9'b00_00110_10;
      4'hF: return 9'b00_00000_01;
      4'hE: return carry ? 9'b00_00000_10 : 9'b00_00000_01;
      default: return 9'b00_00000_10;
    endcase
  endfunction

  // Model: busy flag plus cycle index within the instruction (0..LAT-1 fetch, LAT exec).
  bit         m_busy  [2];
  int         m_k     [2];
  logic [7:0] m_inst  [2];
  bit         m_carry [2];

  always @(posedge clk_cpu or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_busy[d] <= 1'b0; m_k[d] <= 0; m_inst[d] <= 8'h00; m_carry[d] <= 1'b0;
      end else if (!m_busy[d]) begin
        if (run || step) begin m_busy[d] <= 1'b1; m_k[d] <= 0; end
      end else if (m_k[d] < LAT[d]) begin
        if (m_k[d] == LAT[d] - 1) m_inst[d] <= rom_data;
        m_k[d] <= m_k[d] + 1;
      end else begin
        m_carry[d] <= (m_inst[d][7:4] == 4'h0 || m_inst[d][7:4] == 4'h5) ? alu_carry_in : 1'b0;
        if (run) m_k[d] <= 0;
        else m_busy[d] <= 1'b0;
      end
    end
  end

  always @(negedge clk_cpu) begin
    int         es;
    logic [8:0] e, a, em, am;
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        es = !m_busy[d] ? 0 : (m_k[d] < LAT[d]) ? 1 : 2;
        e  = (es == 2) ? spec_ctrl(m_inst[d][7:4], m_carry[d]) : 9'd0;
        a  = {sel_o[d], a_o[d], b_o[d], ol_o[d], os_o[d], iz_o[d], inc_o[d], jmp_o[d]};
        // sel only matters when a register loads; out_src only with out_load
        em = e; am = a;
        if (!(e[6] || e[5])) begin em[8:7] = 2'b00; am[8:7] = 2'b00; end
        if (!e[4]) begin em[3] = 1'b0; am[3] = 1'b0; end
        check("model_state",  d, st_o[d], es);
        check("model_halted", d, halt_o[d], (es == 0));
        check("model_inst",   d, inst_o[d], m_inst[d]);
        check("model_carry",  d, cf_o[d], m_carry[d]);
        check("model_ctrl",   d, am, em);
      end
    end
  end

  task automatic tick();
    @(negedge clk_cpu);
  endtask

  initial begin
    bit found;
    repeat (3) tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("rst_state", d, st_o[d], 0);
      check("rst_inst",  d, inst_o[d], 0);
      check("rst_carry", d, cf_o[d], 0);
      check("rst_halted", d, halt_o[d], 1);
    end

    // single step of MOV A,Im
    rom_data = 8'h35; step = 1'b1;
    tick(); step = 1'b0;
    check("step_fetch", 0, st_o[0], 1);
    tick();
    check("step_exec", 0, st_o[0], 2);
    check("step_sel", 0, sel_o[0], 2'b11);
    check("step_aload", 0, a_o[0], 1);
    check("step_inst", 0, inst_o[0], 8'h35);
    tick();
    check("step_idle", 0, st_o[0], 0);
    check("step_aload_off", 0, a_o[0], 0);
    repeat (4) tick();
    check("nostep_idle", 0, st_o[0], 0);

    // ADD sets carry, following JNC falls through and clears it
    run = 1'b1; rom_data = 8'h0F; alu_carry_in = 1'b1;
    tick();
    check("add_fetch", 0, st_o[0], 1);
    tick();
    check("add_exec_inst", 0, inst_o[0], 8'h0F);
    rom_data = 8'hE3;
    tick();
    check("add_carry", 0, cf_o[0], 1);
    tick();
    check("jnc_nt_inc", 0, inc_o[0], 1);
    check("jnc_nt_jump", 0, jmp_o[0], 0);
    run = 1'b0;
    tick();
    check("jnc_clr_carry", 0, cf_o[0], 0);
    check("run_drop_halt", 0, halt_o[0], 1);

    // JNC taken with carry clear
    repeat (4) tick();
    rom_data = 8'hE7; step = 1'b1;
    tick(); step = 1'b0;
    tick();
    check("jnc_t_jump", 0, jmp_o[0], 1);
    check("jnc_t_inc", 0, inc_o[0], 0);
    tick();

    // run dropped during FETCH, unknown opcode behaves as NOP
    repeat (4) tick();
    run = 1'b1; rom_data = 8'h80;
    tick(); run = 1'b0;
    check("drop_fetch", 0, st_o[0], 1);
    tick();
    check("nop_inc", 0, inc_o[0], 1);
    check("nop_jump", 0, jmp_o[0], 0);
    check("nop_loads", 0, {a_o[0], b_o[0], ol_o[0]}, 0);
    tick();
    check("drop_halted", 0, halt_o[0], 1);

    // ROM_LAT=3 instance: 01,01,01,10 then idle
    repeat (6) tick();
    rom_data = 8'hB5; step = 1'b1;
    tick(); step = 1'b0;
    check("lat3_f1", 1, st_o[1], 1);
    tick();
    check("lat3_f2", 1, st_o[1], 1);
    tick();
    check("lat3_f3", 1, st_o[1], 1);
    tick();
    check("lat3_exec", 1, st_o[1], 2);
    check("lat3_inst", 1, inst_o[1], 8'hB5);
    check("lat3_out", 1, {ol_o[1], os_o[1]}, 2'b11);
    tick();
    check("lat3_idle", 1, st_o[1], 0);

    // async reset in the middle of an EXEC with carry set
    run = 1'b1; rom_data = 8'h0F; alu_carry_in = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (st_o[0] == 2'b10 && cf_o[0] == 1'b1) found = 1'b1;
    end
    check("exec_wait", 0, found, 1);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("arst_state", d, st_o[d], 0);
      check("arst_inst", d, inst_o[d], 0);
      check("arst_carry", d, cf_o[d], 0);
      check("arst_strobes", d, {a_o[d], b_o[d], ol_o[d], inc_o[d], jmp_o[d]}, 0);
    end
    tick();
    reset_n = 1'b1; run = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) run = ~run;
      step         = ($urandom_range(0, 5) == 0);
      rom_data     = 8'($urandom);
      alu_carry_in = 1'($urandom);
    end
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
